beam_delay_scheduler: RTL and testbench

//  Owns the per-tap delay indices (read_index) of the beamformer channel buffers. Host/MCU writes
//  new indices into a shadow bank through a valid/ready port, then requests a commit. The whole

---
 rtl/beam_delay_scheduler.sv | 102 ++++++++++
 tb/tb_beam_delay_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/beam_delay_scheduler.sv
// Per-tap delay index scheduler: the host fills a shadow bank, and the bank is then copied
// atomically to the active outputs on a frame boundary, so every tap switches on the same frame.
module beam_delay_scheduler #(
   parameter int unsigned NUMBER_OF_CHANNELS = 4,
   parameter int unsigned BUFFER_SIZE        = 16,
   parameter int unsigned ADDR_W             = $clog2(2 * NUMBER_OF_CHANNELS) + 1,
   localparam int unsigned NUM_TAPS          = 2 * NUMBER_OF_CHANNELS,
   localparam int unsigned IDX_W             = $clog2(BUFFER_SIZE)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      frame_strobe,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic                      cmd_bcast,
   input  logic [IDX_W-1:0]          cmd_data,
   input  logic                      commit_req,
   input  logic                      commit_abort,
   input  logic                      err_clr,
   output logic [NUM_TAPS*IDX_W-1:0] delay_index,
   output logic                      commit_pending,
   output logic                      applied,
   output logic                      err
);

   typedef enum logic [0:0] {StIdle, StArmed} state_e;

   localparam logic [ADDR_W-1:0] TapLimit = ADDR_W'(NUM_TAPS);

   state_e                    state_q;
   logic [NUM_TAPS*IDX_W-1:0] shadow_q;
   logic [NUM_TAPS*IDX_W-1:0] active_q;
   logic                      applied_q;
   logic                      err_q;

   logic wr_fire;
   logic addr_bad;

   assign wr_fire  = cmd_valid && (state_q == StIdle);
   // The address MSB exists purely so that writes past the last tap can be detected.
   assign addr_bad = !cmd_bcast && (cmd_addr >= TapLimit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         shadow_q  <= '0;
         active_q  <= '0;
         applied_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         applied_q <= 1'b0;

         if (wr_fire) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
               if (cmd_bcast || (cmd_addr == ADDR_W'(i))) begin
                  shadow_q[i*IDX_W +: IDX_W] <= cmd_data;
               end
            end
         end

         // A new error takes priority over a simultaneous clear.
         if (wr_fire && addr_bad) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end

         case (state_q)
            StIdle: begin
               // A strobe here never copies; the copy waits for the next boundary.
               if (commit_req) begin
                  state_q <= StArmed;
               end
            end
            StArmed: begin
               if (commit_abort) begin
                  state_q <= StIdle;
               end else if (frame_strobe) begin
                  active_q  <= shadow_q;
                  applied_q <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd_ready      = (state_q == StIdle);
   assign commit_pending = (state_q == StArmed);
   assign delay_index    = active_q;
   assign applied        = applied_q;
   assign err            = err_q;

   a_applied_idle : assert property (@(posedge clk) disable iff (!rst_n)
      applied_q |-> (state_q == StIdle));

   a_ready_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(cmd_ready && commit_pending));

endmodule

// File: tb/tb_beam_delay_scheduler.sv
// Scoreboarded bench for beam_delay_scheduler: expected active banks are queued at commit time
// and popped by a monitor on every applied pulse.
module tb_beam_delay_scheduler;

   localparam int NT = 8;
   localparam int IW = 4;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_strobe = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic          cmd_bcast = 1'b0;
   logic [IW-1:0] cmd_data = '0;
   logic          commit_req = 1'b0;
   logic          commit_abort = 1'b0;
   logic          err_clr = 1'b0;
   logic [NT*IW-1:0] delay_index;
   logic          commit_pending;
   logic          applied;
   logic          err;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   beam_delay_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .frame_strobe   (frame_strobe),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_addr       (cmd_addr),
      .cmd_bcast      (cmd_bcast),
      .cmd_data       (cmd_data),
      .commit_req     (commit_req),
      .commit_abort   (commit_abort),
      .err_clr        (err_clr),
      .delay_index    (delay_index),
      .commit_pending (commit_pending),
      .applied        (applied),
      .err            (err)
   );

   always #5 clk = ~clk;

   task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [AW-1:0] addr, input logic [IW-1:0] data, input logic bcast);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_bcast = bcast;
      chk1("wr_ready", cmd_ready, 1'b1);
      cyc();
      cmd_valid = 1'b0;
      cmd_bcast = 1'b0;
   endtask

   task automatic commit();
      commit_req = 1'b1;
      cyc();
      commit_req = 1'b0;
   endtask

   task automatic strobe();
      frame_strobe = 1'b1;
      cyc();
      frame_strobe = 1'b0;
   endtask

   // Monitor: every applied pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && applied) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL applied_unexpected actual=%h required=no_pulse", delay_index);
         end else begin
            chkv("applied_bank", delay_index, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      cyc(3);
      rst_n = 1'b1;
      cyc();
      chkv("rst_delay_index", delay_index, 32'h0);
      chk1("rst_ready", cmd_ready, 1'b1);
      chk1("rst_err", err, 1'b0);
      chk1("rst_pending", commit_pending, 1'b0);
      chk1("rst_applied", applied, 1'b0);

      // Basic commit on a later strobe
      wr(4'd3, 4'd5, 1'b0);
      wr(4'd0, 4'd9, 1'b0);
      commit();
      chk1("armed_pending", commit_pending, 1'b1);
      chk1("armed_ready", cmd_ready, 1'b0);
      exp_q.push_back(32'h0000_5009);
      cyc(9);
      chkv("pre_strobe_stable", delay_index, 32'h0);
      strobe();
      chkv("post_strobe", delay_index, 32'h0000_5009);
      chk1("post_strobe_applied", applied, 1'b1);
      chk1("post_strobe_idle", commit_pending, 1'b0);
      cyc();
      chk1("applied_single", applied, 1'b0);

      // Commit and strobe together: arm only
      wr(4'd1, 4'd2, 1'b0);
      commit_req   = 1'b1;
      frame_strobe = 1'b1;
      cyc();
      commit_req   = 1'b0;
      frame_strobe = 1'b0;
      chkv("same_cycle_no_copy", delay_index, 32'h0000_5009);
      chk1("same_cycle_armed", commit_pending, 1'b1);
      cyc(3);
      chkv("same_cycle_hold", delay_index, 32'h0000_5009);
      exp_q.push_back(32'h0000_5029);
      strobe();
      chkv("next_strobe_copy", delay_index, 32'h0000_5029);
      cyc();

      // Stall while armed, abort, abort beats strobe
      commit();
      cmd_valid = 1'b1;
      cmd_addr  = 4'd1;
      cmd_data  = 4'd7;
      #1;
      chk1("stall_ready", cmd_ready, 1'b0);
      cyc(2);
      cmd_valid    = 1'b0;
      commit_abort = 1'b1;
      cyc();
      commit_abort = 1'b0;
      chk1("abort_idle", commit_pending, 1'b0);
      chkv("abort_active", delay_index, 32'h0000_5029);
      commit();
      commit_abort = 1'b1;
      frame_strobe = 1'b1;
      cyc();
      commit_abort = 1'b0;
      frame_strobe = 1'b0;
      chkv("abort_beats_strobe", delay_index, 32'h0000_5029);
      chk1("abort_strobe_idle", commit_pending, 1'b0);
      wr(4'd2, 4'd4, 1'b0);
      exp_q.push_back(32'h0000_5429);
      commit();
      cyc(2);
      strobe();
      chkv("shadow_no_stalled_write", delay_index, 32'h0000_5429);
      cyc();

      // Out-of-range address
      wr(4'd8, 4'd3, 1'b0);
      chk1("err_set", err, 1'b1);
      exp_q.push_back(32'h0000_5429);
      commit();
      strobe();
      chkv("bad_addr_no_change", delay_index, 32'h0000_5429);
      cyc(3);
      chk1("err_sticky", err, 1'b1);
      err_clr = 1'b1;
      wr(4'd9, 4'd3, 1'b0);
      err_clr = 1'b0;
      chk1("err_set_wins", err, 1'b1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk1("err_cleared", err, 1'b0);

      // Broadcast, then reset while armed
      wr(4'd8, 4'hf, 1'b1);
      chk1("bcast_no_err", err, 1'b0);
      exp_q.push_back(32'hffff_ffff);
      commit();
      strobe();
      chkv("bcast_all_taps", delay_index, 32'hffff_ffff);
      cyc();
      wr(4'd0, 4'd1, 1'b0);
      commit();
      chk1("rearmed", commit_pending, 1'b1);
      rst_n = 1'b0;
      #1;
      chkv("async_rst_index", delay_index, 32'h0);
      chk1("async_rst_pending", commit_pending, 1'b0);
      chk1("async_rst_ready", cmd_ready, 1'b1);
      chk1("async_rst_applied", applied, 1'b0);
      cyc(2);
      rst_n = 1'b1;
      cyc();
      exp_q.push_back(32'h0);
      commit();
      strobe();
      chkv("post_rst_shadow_zero", delay_index, 32'h0);

      cyc(3);
      chkv("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
